// File: rtl/riscv_dmi_host.sv
// riscv_dmi_host: on-chip DMI initiator. Takes debug commands on a valid/ready port, issues one
// DMI request at a time toward the debug module, retries BUSY responses after a fixed backoff,
// and returns the final status on a valid/ready result port.
//
// Optional feature: define RISCV_DMI_HOST_TIMEOUT_EN to bound the wait for a DMI response.
// The wait gives up after TIMEOUT_CYCLES with a failed result. The late response is then
// swallowed in a DRAIN state. Without the macro the host waits for a response indefinitely.
//
// DMI widths are set by DMI_ADDR_WIDTH / DMI_DATA_WIDTH / DMI_OP_WIDTH. They mirror the
// debug module's widths.
//
// Ports:
//   clk_i, rst_i                  clock, asynchronous active-high reset
//   cmd_valid_i / cmd_ready_o     command handshake (ready only in IDLE)
//   cmd_addr_i/data_i/op_i        command fields (op 0 nop, 1 read, 2 write, 3 reserved)
//   req_valid_o / req_ready_i     DMI request handshake
//   req_addr_o/data_o/op_o        DMI request fields, stable while req_valid_o is high
//   resp_valid_i / resp_ready_o   DMI response handshake
//   resp_data_i/op_i              DMI response (op 0 success, 2 failed, 3 busy)
//   rslt_valid_o / rslt_ready_i   result handshake
//   rslt_data_o/op_o/retries_o    result data, final status, number of re-issues used
//   busy_o                        host not idle
module riscv_dmi_host #(
   parameter int unsigned DMI_ADDR_WIDTH = 7,
   parameter int unsigned DMI_DATA_WIDTH = 32,
   parameter int unsigned DMI_OP_WIDTH   = 2,
   parameter int unsigned MAX_RETRIES    = 4,
   parameter int unsigned BACKOFF_CYCLES = 8,
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   // At least one bit, so the retry port still exists when MAX_RETRIES is 0.
   localparam int unsigned RETRY_BITS = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      cmd_valid_i,
   output logic                      cmd_ready_o,
   input  logic [DMI_ADDR_WIDTH-1:0] cmd_addr_i,
   input  logic [DMI_DATA_WIDTH-1:0] cmd_data_i,
   input  logic [DMI_OP_WIDTH-1:0]   cmd_op_i,
   output logic                      req_valid_o,
   input  logic                      req_ready_i,
   output logic [DMI_ADDR_WIDTH-1:0] req_addr_o,
   output logic [DMI_DATA_WIDTH-1:0] req_data_o,
   output logic [DMI_OP_WIDTH-1:0]   req_op_o,
   input  logic                      resp_valid_i,
   output logic                      resp_ready_o,
   input  logic [DMI_DATA_WIDTH-1:0] resp_data_i,
   input  logic [DMI_OP_WIDTH-1:0]   resp_op_i,
   output logic                      rslt_valid_o,
   input  logic                      rslt_ready_i,
   output logic [DMI_DATA_WIDTH-1:0] rslt_data_o,
   output logic [DMI_OP_WIDTH-1:0]   rslt_op_o,
   output logic [RETRY_BITS-1:0]     rslt_retries_o,
   output logic                      busy_o
);

   localparam logic [DMI_OP_WIDTH-1:0] OP_FAILED = DMI_OP_WIDTH'(2);
   localparam logic [DMI_OP_WIDTH-1:0] OP_BUSY   = DMI_OP_WIDTH'(3);
   localparam logic [DMI_OP_WIDTH-1:0] CMD_RSVD  = DMI_OP_WIDTH'(3);
   localparam int unsigned BO_BITS = (BACKOFF_CYCLES > 1) ? $clog2(BACKOFF_CYCLES) : 1;
   localparam logic [RETRY_BITS-1:0] RETRY_MAX = RETRY_BITS'(MAX_RETRIES);

   typedef enum logic [2:0] {
      StIdle,
      StReq,
      StWait,
      StBackoff,
      StResult
`ifdef RISCV_DMI_HOST_TIMEOUT_EN
      , StDrain
`endif
   } state_e;

   state_e                    state_q, state_d;
   logic [DMI_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DMI_DATA_WIDTH-1:0] data_q, data_d;
   logic [DMI_OP_WIDTH-1:0]   op_q, op_d;
   logic [RETRY_BITS-1:0]     retries_q, retries_d;
   logic [BO_BITS-1:0]        bo_cnt_q, bo_cnt_d;
   logic [DMI_DATA_WIDTH-1:0] rslt_data_q, rslt_data_d;
   logic [DMI_OP_WIDTH-1:0]   rslt_op_q, rslt_op_d;
   logic                      cmd_ready_q, req_valid_q, resp_ready_q, rslt_valid_q, busy_q;

`ifdef RISCV_DMI_HOST_TIMEOUT_EN
   localparam int unsigned TO_BITS = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [TO_BITS-1:0] to_cnt_q, to_cnt_d;
   // Remembers that the current result came from a timeout, so a late response must be drained.
   logic               timed_out_q, timed_out_d;
`endif

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      data_d      = data_q;
      op_d        = op_q;
      retries_d   = retries_q;
      bo_cnt_d    = bo_cnt_q;
      rslt_data_d = rslt_data_q;
      rslt_op_d   = rslt_op_q;
`ifdef RISCV_DMI_HOST_TIMEOUT_EN
      to_cnt_d    = to_cnt_q;
      timed_out_d = timed_out_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (cmd_valid_i && cmd_ready_q) begin
               addr_d    = cmd_addr_i;
               data_d    = cmd_data_i;
               op_d      = cmd_op_i;
               retries_d = '0;
               if (cmd_op_i == CMD_RSVD) begin
                  // Reserved op is answered locally without touching the DM.
                  rslt_op_d   = OP_FAILED;
                  rslt_data_d = '0;
                  state_d     = StResult;
               end else begin
                  state_d = StReq;
               end
            end
         end
         StReq: begin
            if (req_ready_i) begin
               state_d = StWait;
`ifdef RISCV_DMI_HOST_TIMEOUT_EN
               to_cnt_d = '0;
`endif
            end
         end
         StWait: begin
            if (resp_valid_i) begin
               if (resp_op_i == OP_BUSY && retries_q < RETRY_MAX) begin
                  retries_d = retries_q + 1'b1;
                  bo_cnt_d  = BO_BITS'(BACKOFF_CYCLES - 1);
                  state_d   = StBackoff;
               end else begin
                  rslt_data_d = resp_data_i;
                  rslt_op_d   = resp_op_i;
                  state_d     = StResult;
               end
            end
`ifdef RISCV_DMI_HOST_TIMEOUT_EN
            else if (to_cnt_q == TO_BITS'(TIMEOUT_CYCLES - 1)) begin
               rslt_data_d = '0;
               rslt_op_d   = OP_FAILED;
               timed_out_d = 1'b1;
               state_d     = StResult;
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
`endif
         end
         StBackoff: begin
            if (bo_cnt_q == '0) begin
               state_d = StReq;
            end else begin
               bo_cnt_d = bo_cnt_q - 1'b1;
            end
         end
         StResult: begin
            if (rslt_ready_i) begin
`ifdef RISCV_DMI_HOST_TIMEOUT_EN
               state_d     = timed_out_q ? StDrain : StIdle;
               timed_out_d = 1'b0;
`else
               state_d = StIdle;
`endif
            end
         end
`ifdef RISCV_DMI_HOST_TIMEOUT_EN
         StDrain: begin
            // The response to a timed-out request is accepted and discarded.
            if (resp_valid_i) begin
               state_d = StIdle;
            end
         end
`endif
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= StIdle;
         addr_q       <= '0;
         data_q       <= '0;
         op_q         <= '0;
         retries_q    <= '0;
         bo_cnt_q     <= '0;
         rslt_data_q  <= '0;
         rslt_op_q    <= '0;
         cmd_ready_q  <= 1'b0;
         req_valid_q  <= 1'b0;
         resp_ready_q <= 1'b0;
         rslt_valid_q <= 1'b0;
         busy_q       <= 1'b0;
`ifdef RISCV_DMI_HOST_TIMEOUT_EN
         to_cnt_q     <= '0;
         timed_out_q  <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         data_q       <= data_d;
         op_q         <= op_d;
         retries_q    <= retries_d;
         bo_cnt_q     <= bo_cnt_d;
         rslt_data_q  <= rslt_data_d;
         rslt_op_q    <= rslt_op_d;
         // Handshake flags are decoded from the next state so they line up with state_q.
         cmd_ready_q  <= (state_d == StIdle);
         req_valid_q  <= (state_d == StReq);
`ifdef RISCV_DMI_HOST_TIMEOUT_EN
         resp_ready_q <= (state_d == StWait) || (state_d == StDrain);
         to_cnt_q     <= to_cnt_d;
         timed_out_q  <= timed_out_d;
`else
         resp_ready_q <= (state_d == StWait);
`endif
         rslt_valid_q <= (state_d == StResult);
         busy_q       <= (state_d != StIdle);
      end
   end

   assign cmd_ready_o    = cmd_ready_q;
   assign req_valid_o    = req_valid_q;
   assign req_addr_o     = addr_q;
   assign req_data_o     = data_q;
   assign req_op_o       = op_q;
   assign resp_ready_o   = resp_ready_q;
   assign rslt_valid_o   = rslt_valid_q;
   assign rslt_data_o    = rslt_data_q;
   assign rslt_op_o      = rslt_op_q;
   assign rslt_retries_o = retries_q;
   assign busy_o         = busy_q;

endmodule

// File: tb/tb_riscv_dmi_host.sv
// tb_riscv_dmi_host: randomized scoreboard bench for riscv_dmi_host. A driver issues commands and
// queues the expected result and the DM response plan. A DM responder serves requests from the
// plan. A result monitor pops and compares. Timeout checks apply when RISCV_DMI_HOST_TIMEOUT_EN
// is defined.
module tb_riscv_dmi_host;

   localparam int MAXR = 4;
   localparam int BO   = 8;
   localparam int TO   = 16;

   logic        clk_i, rst_i;
   logic        cmd_valid_i, cmd_ready_o;
   logic [6:0]  cmd_addr_i;
   logic [31:0] cmd_data_i;
   logic [1:0]  cmd_op_i;
   logic        req_valid_o, req_ready_i;
   logic [6:0]  req_addr_o;
   logic [31:0] req_data_o;
   logic [1:0]  req_op_o;
   logic        resp_valid_i, resp_ready_o;
   logic [31:0] resp_data_i;
   logic [1:0]  resp_op_i;
   logic        rslt_valid_o, rslt_ready_i;
   logic [31:0] rslt_data_o;
   logic [1:0]  rslt_op_o;
   logic [2:0]  rslt_retries_o;
   logic        busy_o;

   riscv_dmi_host #(
      .DMI_ADDR_WIDTH(7),
      .DMI_DATA_WIDTH(32),
      .DMI_OP_WIDTH  (2),
      .MAX_RETRIES   (MAXR),
      .BACKOFF_CYCLES(BO),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .cmd_valid_i   (cmd_valid_i),
      .cmd_ready_o   (cmd_ready_o),
      .cmd_addr_i    (cmd_addr_i),
      .cmd_data_i    (cmd_data_i),
      .cmd_op_i      (cmd_op_i),
      .req_valid_o   (req_valid_o),
      .req_ready_i   (req_ready_i),
      .req_addr_o    (req_addr_o),
      .req_data_o    (req_data_o),
      .req_op_o      (req_op_o),
      .resp_valid_i  (resp_valid_i),
      .resp_ready_o  (resp_ready_o),
      .resp_data_i   (resp_data_i),
      .resp_op_i     (resp_op_i),
      .rslt_valid_o  (rslt_valid_o),
      .rslt_ready_i  (rslt_ready_i),
      .rslt_data_o   (rslt_data_o),
      .rslt_op_o     (rslt_op_o),
      .rslt_retries_o(rslt_retries_o),
      .busy_o        (busy_o)
   );

   typedef struct {
      logic [6:0]  addr;
      logic [31:0] data;
      logic [1:0]  op;
      int          ready_dly;
      int          resp_dly;
      logic [1:0]  rop;
      logic [31:0] rdata;
      bit          retry;
      bit          hang;
      bit          late;
   } plan_t;

   typedef struct {
      logic [31:0] data;
      logic [1:0]  op;
      logic [2:0]  retries;
      int          lat;
   } exp_t;

   plan_t plan_q[$];
   exp_t  exp_q[$];
   int    checks = 0;
   int    failures = 0;
   int    cycle = 0;
   int    acc_cycle = 0;
   int    last_resp = 0;

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   always @(posedge clk_i) cycle <= cycle + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_cmd_ready"}, cmd_ready_o, 0);
      chk({tag, "_req_valid"}, req_valid_o, 0);
      chk({tag, "_req_fields"}, {req_addr_o, req_data_o, req_op_o}, 0);
      chk({tag, "_resp_ready"}, resp_ready_o, 0);
      chk({tag, "_rslt_valid"}, rslt_valid_o, 0);
      chk({tag, "_rslt_fields"}, {rslt_data_o, rslt_op_o, rslt_retries_o}, 0);
      chk({tag, "_busy"}, busy_o, 0);
   endtask

   // Result monitor: compares the first cycle of every result, then checks it holds until consumed.
   initial begin
      exp_t e;
      bit seen = 0;
      logic [36:0] held = '0;
      rslt_ready_i = 1'b0;
      forever begin
         @(negedge clk_i);
         if (rst_i) begin
            seen = 0;
            rslt_ready_i = 1'b0;
         end else if (rslt_valid_o) begin
            if (!seen) begin
               seen = 1;
               held = {rslt_data_o, rslt_op_o, rslt_retries_o};
               if (exp_q.size() == 0) begin
                  chk("stray_rslt", rslt_valid_o, 0);
               end else begin
                  e = exp_q.pop_front();
                  chk("rslt_data", rslt_data_o, e.data);
                  chk("rslt_op", rslt_op_o, e.op);
                  chk("rslt_retries", rslt_retries_o, e.retries);
                  if (e.lat >= 0) chk("rslt_latency", cycle - acc_cycle, e.lat);
               end
            end else begin
               chk("rslt_stable", {rslt_data_o, rslt_op_o, rslt_retries_o}, held);
            end
            rslt_ready_i = ($urandom_range(0, 2) != 0);
         end else begin
            seen = 0;
            rslt_ready_i = 1'b0;
         end
      end
   end

   // DM responder: serves each request from the plan, honouring the planned delays.
   initial begin
      plan_t p;
      bit stable_bad;
      bit stray = 0;
      int hs;
      int n;
      req_ready_i  = 1'b0;
      resp_valid_i = 1'b0;
      resp_data_i  = '0;
      resp_op_i    = '0;
      forever begin
         @(negedge clk_i);
         if (rst_i || !req_valid_o) continue;
         if (plan_q.size() == 0) begin
            if (!stray) chk("stray_req", req_valid_o, 0);
            stray = 1;
            continue;
         end
         p = plan_q.pop_front();
         chk("req_fields", {req_addr_o, req_data_o, req_op_o}, {p.addr, p.data, p.op});
         stable_bad = 0;
         for (int i = 0; i < p.ready_dly; i++) begin
            @(negedge clk_i);
            if (!req_valid_o || {req_addr_o, req_data_o, req_op_o} != {p.addr, p.data, p.op})
               stable_bad = 1;
         end
         req_ready_i = 1'b1;
         @(negedge clk_i);
         req_ready_i = 1'b0;
         hs = cycle;
         if (p.ready_dly > 0) chk("req_stable", stable_bad, 0);
         chk("req_drop", req_valid_o, 0);
         if (p.retry) chk("backoff_gap", (hs - last_resp) >= BO + 1, 1);
         if (p.hang) continue;
         repeat (p.resp_dly) @(negedge clk_i);
         resp_valid_i = 1'b1;
         resp_data_i  = p.rdata;
         resp_op_i    = p.rop;
         if (!p.late) chk("resp_ready", resp_ready_o, 1);
         n = 0;
         while (!resp_ready_o && n <= 300) begin
            @(negedge clk_i);
            n++;
         end
         if (n > 300) chk("resp_accept_timeout", resp_ready_o, 1);
         @(negedge clk_i);
         resp_valid_i = 1'b0;
         last_resp = cycle;
         if (p.late) chk("drain_exit_cmd_ready", cmd_ready_o, 1);
      end
   end

   task automatic issue(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] data);
      int n = 0;
      @(negedge clk_i);
      while (!cmd_ready_o) begin
         n++;
         if (n > 1000) begin
            chk("cmd_ready_timeout", cmd_ready_o, 1);
            return;
         end
         @(negedge clk_i);
      end
      cmd_valid_i = 1'b1;
      cmd_addr_i  = addr;
      cmd_data_i  = data;
      cmd_op_i    = op;
      acc_cycle   = cycle;
      @(negedge clk_i);
      cmd_valid_i = 1'b0;
      cmd_addr_i  = $urandom;
      cmd_data_i  = $urandom;
      cmd_op_i    = $urandom;
      chk("cmd_ready_low", cmd_ready_o, 0);
   endtask

   // Reference model: walks the planned DM responses with the retry rule and queues the result.
   // mode: 0 normal, 1 never answered, 2 answered only after the timeout.
   task automatic run_txn(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] data,
                          input int n_busy, input logic [1:0] fin_op, input int rdly,
                          input int sdly, input bit fixed, input logic [31:0] fdata,
                          input int lat, input int mode);
      plan_t p;
      exp_t  e;
      int    retries = 0;
      p.addr = addr; p.data = data; p.op = op;
      p.ready_dly = rdly; p.resp_dly = sdly;
      p.hang = (mode == 1); p.late = (mode == 2); p.retry = 0;
      p.rop = 2'd0; p.rdata = $urandom;
      if (op == 2'd3) begin
         e = '{data: 32'd0, op: 2'd2, retries: 3'd0, lat: lat};
         exp_q.push_back(e);
      end else if (mode == 1) begin
         plan_q.push_back(p);
      end else if (mode == 2) begin
         p.resp_dly = 30;
         plan_q.push_back(p);
         e = '{data: 32'd0, op: 2'd2, retries: 3'd0, lat: lat};
         exp_q.push_back(e);
      end else begin
         for (int i = 0; i < 64; i++) begin
            p.rop   = (i < n_busy) ? 2'd3 : fin_op;
            p.rdata = fixed ? fdata : $urandom;
            p.retry = (i > 0);
            plan_q.push_back(p);
            if (p.rop == 2'd3 && retries < MAXR) begin
               retries++;
            end else begin
               e = '{data: p.rdata, op: p.rop, retries: 3'(retries), lat: lat};
               exp_q.push_back(e);
               break;
            end
         end
      end
      issue(op, addr, data);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (exp_q.size() != 0 || plan_q.size() != 0 || !cmd_ready_o) begin
         @(negedge clk_i);
         n++;
         if (n > 3000) begin
            checks++;
            failures++;
            $display("FAIL idle_timeout actual=pending(%0d,%0d) required=idle",
                     exp_q.size(), plan_q.size());
            return;
         end
      end
   endtask

   initial begin
      logic [1:0] op;
      int r;
      rst_i       = 1'b1;
      cmd_valid_i = 1'b0;
      cmd_addr_i  = '0;
      cmd_data_i  = '0;
      cmd_op_i    = '0;
      repeat (3) @(negedge clk_i);
      check_all_zero("reset");
      rst_i = 1'b0;
      @(negedge clk_i);
      chk("post_reset_cmd_ready", cmd_ready_o, 1);
      chk("post_reset_busy", busy_o, 0);

      // Write at minimum latency.
      run_txn(2'd2, 7'h10, 32'h1, 0, 2'd0, 0, 0, 0, 0, 3, 0);
      wait_idle();
      // Read with 5 cycles of request backpressure.
      run_txn(2'd1, 7'h11, 32'h0, 0, 2'd0, 5, 0, 1, 32'hDEADBEEF, -1, 0);
      wait_idle();
      // Two BUSY responses, then success.
      run_txn(2'd1, 7'h04, 32'h0, 2, 2'd0, 0, 1, 0, 0, -1, 0);
      wait_idle();
      // BUSY forever: exhausts the retries.
      run_txn(2'd2, 7'h17, 32'hA5A5_0001, 5, 2'd0, 1, 0, 0, 0, -1, 0);
      wait_idle();
      // Reserved op is answered locally one cycle after acceptance.
      run_txn(2'd3, 7'h22, 32'h1234_5678, 0, 2'd0, 0, 0, 0, 0, 1, 0);
      wait_idle();

      // Reset while waiting for a response: everything clears, no result appears.
      run_txn(2'd1, 7'h05, 32'h0, 0, 2'd0, 0, 0, 0, 0, -1, 1);
      repeat (4) @(negedge clk_i);
      chk("in_wait_resp_ready", resp_ready_o, 1);
      rst_i = 1'b1;
      @(negedge clk_i);
      check_all_zero("midrst");
      rst_i = 1'b0;
      @(negedge clk_i);
      chk("midrst_cmd_ready", cmd_ready_o, 1);
      chk("midrst_busy", busy_o, 0);
      repeat (10) @(negedge clk_i);

`ifdef RISCV_DMI_HOST_TIMEOUT_EN
      // No response: fail after TO wait cycles, then drain the late response.
      run_txn(2'd1, 7'h30, 32'h0, 0, 2'd0, 0, 0, 0, 0, TO + 2, 2);
      wait_idle();
`endif

      for (int t = 0; t < 40; t++) begin
         r = $urandom_range(0, 7);
         op = (r == 0) ? 2'd0 : (r <= 3) ? 2'd1 : (r <= 6) ? 2'd2 : 2'd3;
         run_txn(op, 7'($urandom), $urandom,
                 ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : 0,
                 2'($urandom_range(0, 2)), $urandom_range(0, 3), $urandom_range(0, 4),
                 0, 0, -1, 0);
         repeat ($urandom_range(0, 3)) @(negedge clk_i);
      end
      wait_idle();
      repeat (5) @(negedge clk_i);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
